// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with the IF/ID pipeline register.
// The PC drives instruction memory combinationally. Each cycle in RUN resolves
// exactly one action, in this priority order:
//   halt -> stall -> redirect (branch/jump) -> advance.
// halt and pcSource are only honoured while IF/ID holds a real instruction.
// HALTED is sticky, and only rst leaves it.
//
// Ports
//   clk           : clock; all state updates on the rising edge
//   rst           : asynchronous active-high reset
//   stall         : hazard hold request for the IF/ID stage
//   pcSource[1:0] : next-PC select (00 seq, 01 branch, 10 jump, 11 reserved)
//   halt          : halt request for the instruction held in IF/ID
//   branchTarget  : branch destination
//   jumpTarget    : jump destination
//   imemAddr      : instruction memory address (= PC)
//   imemData      : instruction word at imemAddr, valid in the same cycle
//   ifidInstr     : registered instruction
//   ifidPcPlus2   : registered PC+2 of that instruction
//   ifidValid     : 1 = real instruction, 0 = bubble
//   opCode        : ifidInstr[15:12]
//   functionCode  : ifidInstr[3:0]
//   halted        : 1 while in HALTED
//   fetchCount    : saturating count of instructions latched valid
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pcSource,
  input  logic        halt,
  input  logic [15:0] branchTarget,
  input  logic [15:0] jumpTarget,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  output logic [15:0] ifidInstr,
  output logic [15:0] ifidPcPlus2,
  output logic        ifidValid,
  output logic [3:0]  opCode,
  output logic [3:0]  functionCode,
  output logic        halted,
  output logic [15:0] fetchCount
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc_plus2_q, ifid_pc_plus2_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] pc_plus2;

  // Wraps modulo 2^16 naturally.
  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus2_d = ifid_pc_plus2_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;

    if (state_q == RUN) begin
      if (halt && ifid_valid_q) begin
        // Freeze the PC and squash IF/ID. ifidPcPlus2 keeps its last value.
        state_d      = HALTED;
        ifid_instr_d = 16'h0000;
        ifid_valid_d = 1'b0;
      end else if (stall) begin
        // Hold everything. A pending redirect waits until the stall clears.
      end else if (ifid_valid_q && (pcSource == 2'b01 || pcSource == 2'b10)) begin
        // The word fetched this cycle is on the wrong path, so drop it.
        pc_d         = (pcSource == 2'b01) ? branchTarget : jumpTarget;
        ifid_instr_d = 16'h0000;
        ifid_valid_d = 1'b0;
      end else begin
        pc_d            = pc_plus2;
        ifid_instr_d    = imemData;
        ifid_pc_plus2_d = pc_plus2;
        ifid_valid_d    = 1'b1;
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      pc_q            <= RESET_PC;
      ifid_instr_q    <= 16'h0000;
      ifid_pc_plus2_q <= 16'h0000;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= 16'h0000;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus2_q <= ifid_pc_plus2_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign imemAddr     = pc_q;
  assign ifidInstr    = ifid_instr_q;
  assign ifidPcPlus2  = ifid_pc_plus2_q;
  assign ifidValid    = ifid_valid_q;
  assign opCode       = ifid_instr_q[15:12];
  assign functionCode = ifid_instr_q[3:0];
  assign halted       = (state_q == HALTED);
  assign fetchCount   = fetch_count_q;

endmodule
